// File: rtl/burst_read_arbiter_if.sv
// Requester-side and pipeline-side signals of the burst read arbiter.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface burst_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ*ADDR_WIDTH-1:0] r_addr;
  logic [NUM_REQ*8-1:0]          r_length;
  logic [NUM_REQ-1:0]            r_valid;
  logic [NUM_REQ-1:0]            r_ready;
  logic [DATA_WIDTH-1:0]         r_data;
  logic [NUM_REQ-1:0]            r_dvalid;
  logic                          r_dlast;
  logic [NUM_REQ-1:0]            r_dready;
  logic [ADDR_WIDTH-1:0]         m_addr;
  logic [7:0]                    m_length;
  logic                          m_valid;
  logic                          m_ready;
  logic [DATA_WIDTH-1:0]         s_data;
  logic                          s_valid;
  logic                          s_last;
  logic                          s_ready;

  modport slave (
    input  r_addr, r_length, r_valid, r_dready, m_ready, s_data, s_valid, s_last,
    output r_ready, r_data, r_dvalid, r_dlast, m_addr, m_length, m_valid, s_ready
  );

  modport master (
    output r_addr, r_length, r_valid, r_dready, m_ready, s_data, s_valid, s_last,
    input  r_ready, r_data, r_dvalid, r_dlast, m_addr, m_length, m_valid, s_ready
  );
endinterface

// File: rtl/burst_read_arbiter.sv
// Round-robin arbiter sharing one burst read pipeline between NUM_REQ requesters;
// an in-order ID FIFO steers each returning burst back to the requester that issued it.
module burst_read_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  burst_read_arbiter_if.slave bus,
  output logic                busy,
  output logic                orphan_err
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(ORDER_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic [ID_W-1:0]      g_id_r, g_id_nxt_s, rr_ptr_r, rr_ptr_nxt_s;
  logic [ID_W-1:0]      pick_s, off_s;
  logic                 pick_vld_s;
  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [ID_W:0]        sum_s;
  logic                 accept_s, push_s, pop_s, empty_s;
  logic [ID_W-1:0]      head_s;
  logic [ID_W-1:0]      fifo_mem_r [ORDER_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     cnt_r;

  // Rotating the doubled request vector by rr_ptr turns the wrapped search into a lowest-set-bit search.
  assign dbl_s = {bus.r_valid, bus.r_valid};
  assign rot_s = dbl_s[rr_ptr_r +: NUM_REQ];

  // Round-robin winner selection.
  always_comb begin
    off_s      = '0;
    pick_vld_s = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      off_s      = rot_s[k] ? ID_W'(k) : off_s;
      pick_vld_s = pick_vld_s | rot_s[k];
    end
    sum_s  = {1'b0, rr_ptr_r} + {1'b0, off_s};
    pick_s = (sum_s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum_s - (ID_W+1)'(NUM_REQ)) : sum_s[ID_W-1:0];
  end

  // Command FSM state, locked grant and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_ARB;
      g_id_r   <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      g_id_r   <= g_id_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Next-state logic; a grant is held until the pipeline accepts it.
  always_comb begin
    state_nxt_s  = state_r;
    g_id_nxt_s   = g_id_r;
    rr_ptr_nxt_s = rr_ptr_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_ARB: begin
        if (pick_vld_s && (cnt_r < CNT_W'(ORDER_DEPTH))) begin
          state_nxt_s = ST_GRANT;
          g_id_nxt_s  = pick_s;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_GRANT: begin
        if (bus.m_ready) begin
          accept_s     = 1'b1;
          state_nxt_s  = ST_ARB;
          rr_ptr_nxt_s = (g_id_r == ID_W'(NUM_REQ - 1)) ? '0 : g_id_r + ID_W'(1);
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: state_nxt_s = ST_ARB;
    endcase
  end

  // Forward the granted requester's command upstream.
  always_comb begin
    bus.m_valid  = 1'b0;
    bus.m_addr   = '0;
    bus.m_length = '0;
    bus.r_ready  = '0;
    if (state_r == ST_GRANT) begin
      bus.m_valid         = 1'b1;
      bus.m_addr          = bus.r_addr[int'(g_id_r)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.m_length        = bus.r_length[int'(g_id_r)*8 +: 8];
      bus.r_ready[g_id_r] = bus.m_ready;
    end else begin
      bus.m_valid = 1'b0;
    end
  end

  assign empty_s = (cnt_r == '0);
  assign head_s  = fifo_mem_r[rd_ptr_r];

  // Response steering; an empty FIFO keeps s_ready high so an idle pipeline can take commands.
  always_comb begin
    bus.r_data   = bus.s_data;
    bus.r_dlast  = bus.s_last;
    bus.r_dvalid = '0;
    bus.s_ready  = 1'b1;
    if (!empty_s) begin
      bus.r_dvalid[head_s] = bus.s_valid;
      bus.s_ready          = bus.r_dready[head_s];
    end else begin
      bus.s_ready = 1'b1;
    end
  end

  assign push_s = accept_s;
  assign pop_s  = bus.s_valid && bus.s_ready && bus.s_last && !empty_s;
  assign busy   = (state_r == ST_GRANT) || !empty_s;

  // In-order owner FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      for (int i = 0; i < ORDER_DEPTH; i++) fifo_mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= g_id_r;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky flag for a beat with no recorded owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orphan_err <= 1'b0;
    end else if (bus.s_valid && empty_s) begin
      orphan_err <= 1'b1;
    end else begin
      orphan_err <= orphan_err;
    end
  end
endmodule

// File: tb/tb_burst_read_arbiter.sv
// Scoreboard bench for burst_read_arbiter: a behavioural pipeline serves commands,
// expected commands and beats are queued at issue time and popped by negedge monitors.
`timescale 1ns/1ps
module tb_burst_read_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  burst_read_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  burst_read_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();
  logic busy, orphan_err, busy2, orphan_err2;

  burst_read_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ORDER_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .orphan_err(orphan_err));
  burst_read_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ORDER_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2), .orphan_err(orphan_err2));

  logic [NR*AW-1:0] req_addr;
  logic [NR*8-1:0]  req_len;
  logic [NR-1:0]    req_valid, dready, req2_valid, dready2;
  logic             m_ready_en, orphan_inj, sv2, sl2;
  logic             pv = 1'b0;
  logic             plast = 1'b0;
  logic [DW-1:0]    pdata = '0;

  assign bus.r_addr   = req_addr;
  assign bus.r_length = req_len;
  assign bus.r_valid  = req_valid;
  assign bus.r_dready = dready;
  assign bus.m_ready  = m_ready_en & bus.s_ready;
  assign bus.s_valid  = pv | orphan_inj;
  assign bus.s_data   = pdata;
  assign bus.s_last   = plast;

  assign bus2.r_addr   = {32'h0000_2300, 32'h0000_2200, 32'h0000_2100, 32'h0000_2000};
  assign bus2.r_length = '0;
  assign bus2.r_valid  = req2_valid;
  assign bus2.r_dready = dready2;
  assign bus2.m_ready  = 1'b1;
  assign bus2.s_valid  = sv2;
  assign bus2.s_data   = 32'h0000_0BAD;
  assign bus2.s_last   = sl2;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_evt(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endfunction

  typedef struct {int id; logic [AW-1:0] addr; logic [7:0] len;} exp_cmd_t;
  typedef struct {int id; logic [DW-1:0] data; logic last;} exp_beat_t;
  typedef struct {logic [AW-1:0] addr; logic [7:0] len;} pcmd_t;
  exp_cmd_t  exp_cmd[$];
  exp_beat_t exp_beat[$];
  pcmd_t     pq[$];
  int        beat = 0;

  // Behavioural pipeline: zero-latency, returns addr+k for beat k.
  always @(posedge clk) begin
    logic  rs, do_cmd, do_beat;
    pcmd_t c;
    rs      = rst_n;
    do_cmd  = rst_n && bus.m_valid && bus.m_ready;
    c.addr  = bus.m_addr;
    c.len   = bus.m_length;
    do_beat = rst_n && pv && bus.s_ready;
    #1;
    if (!rs) begin
      pq.delete();
      beat = 0;
    end else begin
      if (do_cmd) pq.push_back(c);
      if (do_beat) begin
        if (beat == int'(pq[0].len)) begin
          void'(pq.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
    end
    if (pq.size() > 0) begin
      pv    = 1'b1;
      pdata = pq[0].addr + AW'(beat);
      plast = (beat == int'(pq[0].len));
    end else begin
      pv    = 1'b0;
      pdata = '0;
      plast = 1'b0;
    end
  end

  // Monitors: command and beat handshakes that complete at the next rising edge.
  always @(negedge clk) begin
    exp_cmd_t  ec;
    exp_beat_t eb;
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_cmd.size() == 0) begin
        fail_evt("cmd_unexpected");
      end else begin
        ec = exp_cmd.pop_front();
        chk("cmd_addr", 64'(bus.m_addr), 64'(ec.addr));
        chk("cmd_len", 64'(bus.m_length), 64'(ec.len));
        chk("cmd_r_ready", 64'(bus.r_ready), 64'(1) << ec.id);
      end
    end
    if (rst_n && bus.s_valid && bus.s_ready) begin
      if (orphan_inj) begin
        chk("orphan_r_dvalid", 64'(bus.r_dvalid), 64'(0));
      end else if (exp_beat.size() == 0) begin
        fail_evt("beat_unexpected");
      end else begin
        eb = exp_beat.pop_front();
        chk("beat_r_dvalid", 64'(bus.r_dvalid), 64'(1) << eb.id);
        chk("beat_data", 64'(bus.r_data), 64'(eb.data));
        chk("beat_last", 64'(bus.r_dlast), 64'(eb.last));
      end
    end
  end

  task automatic step();
    logic [NR-1:0] a1, a2;
    @(posedge clk);
    a1 = req_valid & bus.r_ready;
    a2 = req2_valid & bus2.r_ready;
    #2;
    req_valid  = req_valid & ~a1;
    req2_valid = req2_valid & ~a2;
  endtask

  task automatic issue(input int id, input logic [AW-1:0] addr, input logic [7:0] len);
    req_addr[id*AW +: AW] = addr;
    req_len[id*8 +: 8]    = len;
    req_valid[id]         = 1'b1;
  endtask

  task automatic expect_burst(input int id, input logic [AW-1:0] addr, input logic [7:0] len);
    exp_cmd_t  ec;
    exp_beat_t eb;
    ec.id = id; ec.addr = addr; ec.len = len;
    exp_cmd.push_back(ec);
    for (int b = 0; b <= int'(len); b++) begin
      eb.id = id; eb.data = addr + AW'(b); eb.last = (b == int'(len));
      exp_beat.push_back(eb);
    end
  endtask

  task automatic run_until_done(input string name, input int max_cyc);
    logic done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      step();
      done = (req_valid == '0) && (exp_cmd.size() == 0) && (exp_beat.size() == 0) && !busy;
    end
    chk({"done_", name}, 64'(done), 64'(1));
    chk({"idle_s_ready_", name}, 64'(bus.s_ready), 64'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'(0));
    chk({tag, "_r_ready"}, 64'(bus.r_ready), 64'(0));
    chk({tag, "_r_dvalid"}, 64'(bus.r_dvalid), 64'(0));
    chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_orphan"}, 64'(orphan_err), 64'(0));
  endtask

  initial begin
    logic [3:0] pat;
    logic       seen;
    int         acc_cnt;
    req_addr = '0; req_len = '0; req_valid = '0; dready = '1;
    req2_valid = '0; dready2 = '0; sv2 = 1'b0; sl2 = 1'b0;
    m_ready_en = 1'b1; orphan_inj = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    step(); step(); step();
    rst_n = 1'b1;
    step();
    chk_reset_outputs("after_reset");

    // Contention: all four at once from rr_ptr 0, twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) issue(i, AW'(32'h1000 + r*32'h100 + i*32'h10), 8'd1);
      for (int i = 0; i < NR; i++) expect_burst(i, AW'(32'h1000 + r*32'h100 + i*32'h10), 8'd1);
      run_until_done("contention", 100);
    end
    issue(3, 32'h0000_3300, 8'd0);
    expect_burst(3, 32'h0000_3300, 8'd0);
    run_until_done("req3_only", 40);
    issue(0, 32'h0000_4000, 8'd0);
    issue(3, 32'h0000_4300, 8'd0);
    expect_burst(0, 32'h0000_4000, 8'd0);
    expect_burst(3, 32'h0000_4300, 8'd0);
    run_until_done("req0_req3", 40);

    // Single burst with arbitration latency.
    issue(2, 32'h0000_0100, 8'd3);
    expect_burst(2, 32'h0000_0100, 8'd3);
    #1 chk("lat_cycle_n", 64'(bus.m_valid), 64'(0));
    step();
    #1 chk("lat_cycle_n1", 64'(bus.m_valid), 64'(1));
    run_until_done("single", 40);
    chk("single_busy", 64'(busy), 64'(0));

    // Backpressure from requester 1 mid-burst.
    issue(1, 32'h0000_0300, 8'd5);
    expect_burst(1, 32'h0000_0300, 8'd5);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      seen = bus.r_dvalid[1];
    end
    chk("bp_first_beat", 64'(seen), 64'(1));
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      dready[1] = pat[3-k];
      #1 chk("bp_s_ready", 64'(bus.s_ready), 64'(pat[3-k]));
      step();
    end
    dready[1] = 1'b1;
    run_until_done("backpressure", 40);

    // Reset during beat 2 of a length-7 burst.
    issue(0, 32'h0000_0700, 8'd7);
    expect_burst(0, 32'h0000_0700, 8'd7);
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      seen = bus.r_dvalid[0] && (bus.r_data == 32'h0000_0702);
    end
    chk("rst_reached_beat2", 64'(seen), 64'(1));
    rst_n = 1'b0;
    #1 chk_reset_outputs("midburst_reset");
    chk("rst_beats_left", 64'(exp_beat.size()), 64'(6));
    exp_beat.delete();
    exp_cmd.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    issue(1, 32'h0000_0800, 8'd1);
    expect_burst(1, 32'h0000_0800, 8'd1);
    run_until_done("post_reset", 40);

    // Orphan beat with the FIFO empty.
    orphan_inj = 1'b1;
    #1 chk("orphan_before", 64'(orphan_err), 64'(0));
    step();
    orphan_inj = 1'b0;
    #1 chk("orphan_set", 64'(orphan_err), 64'(1));
    step(); step(); step();
    chk("orphan_sticky", 64'(orphan_err), 64'(1));
    chk("orphan_no_dvalid", 64'(bus.r_dvalid), 64'(0));

    // FIFO full on the depth-2 instance.
    req2_valid = 4'b0111;
    acc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus2.m_valid && bus2.m_ready) acc_cnt++;
      step();
    end
    chk("full_accepts", 64'(acc_cnt), 64'(2));
    chk("full_m_valid_low", 64'(bus2.m_valid), 64'(0));
    chk("full_busy", 64'(busy2), 64'(1));
    chk("full_pending", 64'(req2_valid), 64'(4'b0100));
    sv2 = 1'b1; sl2 = 1'b1; dready2 = 4'b0001;
    #1 chk("full_pop_r_dvalid", 64'(bus2.r_dvalid), 64'(4'b0001));
    step();
    sv2 = 1'b0; sl2 = 1'b0; dready2 = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      #1 seen = bus2.m_valid;
      if (!seen) step();
    end
    chk("full_third_m_valid", 64'(seen), 64'(1));
    chk("full_third_r_ready", 64'(bus2.r_ready), 64'(4'b0100));
    chk("full_m_addr", 64'(bus2.m_addr), 64'(32'h0000_2200));
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/burst_read_arbiter.md
# burst_read_arbiter

Shares one burst read pipeline between NUM_REQ requesters. Round-robin arbitration selects one pending burst command at a time and forwards it to the pipeline's upstream port. An in-order ID FIFO records the owner of each accepted burst. Returning data beats are steered to that owner, and the pipeline's downstream ready is driven from the owner's ready.

## Interface
- NUM_REQ, 4, number of requesters (2..8); ID_W = $clog2(NUM_REQ) is a localparam
- DATA_WIDTH, 32, data beat width
- ADDR_WIDTH, 32, burst start address width
- ORDER_DEPTH, 4, ID FIFO depth (power of 2, ≥2); maximum bursts outstanding
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- r_addr  in  NUM_REQ*ADDR_WIDTH  per-requester start address; requester i occupies slice i
- r_length  in  NUM_REQ*8  per-requester burst length minus 1
- r_valid  in  NUM_REQ  per-requester command valid
- r_ready  out  NUM_REQ  per-requester command accept
- r_data  out  DATA_WIDTH  read data, broadcast to all requesters
- r_dvalid  out  NUM_REQ  per-requester data valid
- r_dlast  out  1  last beat of burst, broadcast
- r_dready  in  NUM_REQ  per-requester data ready
- m_addr / m_length / m_valid  out  ADDR_WIDTH / 8 / 1  command to pipeline upstream port
- m_ready  in  1  pipeline upstream ready
- s_data / s_valid / s_last  in  DATA_WIDTH / 1 / 1  pipeline downstream output
- s_ready  out  1  pipeline downstream ready
- busy  out  1  grant pending, or FIFO not empty
- orphan_err  out  1  sticky: a beat arrived while the FIFO was empty

## Operation
- Command FSM has two states.
  - ARB: no grant held. If cnt < ORDER_DEPTH and any r_valid is high, pick the first requester with r_valid high, searching upward from rr_ptr and wrapping modulo NUM_REQ. Latch the winner into g_id and go to GRANT.
  - GRANT: m_valid = 1, m_addr = r_addr[g_id], m_length = r_length[g_id]. r_ready[g_id] = m_ready. All other r_ready bits are 0.
  - Accept occurs on m_valid && m_ready. On accept: push g_id into the FIFO, set rr_ptr = (g_id+1) mod NUM_REQ, return to ARB.
  - The grant is locked. Once in GRANT, the FSM does not re-arbitrate until accept.
  - A requester must hold r_valid, r_addr and r_length stable until r_ready. Behaviour when a requester withdraws r_valid while granted is undefined.
- Response routing, with h = FIFO head:
  - r_data = s_data, r_dlast = s_last.
  - r_dvalid[i] = s_valid && !empty && (h == i).
  - s_ready = empty ? 1 : r_dready[h].
  - s_ready is 1 when the FIFO is empty because the pipeline gates command acceptance on its downstream ready; this lets it accept a command while idle.
  - Pop the FIFO on s_valid && s_ready && s_last && !empty.
- FIFO: ORDER_DEPTH entries of ID_W bits with separate read/write pointers. Pointers wrap modulo ORDER_DEPTH. cnt is ID_W-independent and has width $clog2(ORDER_DEPTH)+1.
  - Push and pop in the same cycle leave cnt unchanged.
  - Push while full cannot occur: a grant requires cnt < ORDER_DEPTH, and only one grant is outstanding at a time.
  - Pop while empty never happens.
- orphan_err sets on s_valid && empty. It is cleared only by reset.

## Timing
- Reset values: state ARB, g_id 0, rr_ptr 0, FIFO empty, orphan_err 0.
  - Hence m_valid 0, r_ready all 0, r_dvalid all 0, s_ready 1, busy 0.
- Reset mid-burst abandons all outstanding bursts. The pipeline is reset by the same rst_n.
- Arbitration latency: r_valid seen in cycle N (FSM in ARB) → m_valid high in cycle N+1. Accept at the earliest in N+1.
- Command throughput: at most one command every 2 cycles (ARB and GRANT alternate).
- The response path is purely combinational, with no added latency on data, valid, last or ready.
- While the head requester holds r_dready low, s_ready is low. The pipeline then stalls, which also blocks m_ready, so no new commands are accepted.

## Test plan
- Single burst: requester 2 issues addr 0x100, length 3 → m_valid one cycle later; 4 beats data 0x100..0x103 appear on r_dvalid[2] only; r_dlast on 0x103; FIFO returns to empty; busy falls.
- Contention: all 4 requesters valid at once, rr_ptr 0 → grant order 0,1,2,3. Repeating the requests → order 0,1,2,3 again. Request from 3 only, then 0 and 3 together → 3, then 0.
- Backpressure: requester 1 toggles r_dready 1,0,0,1 mid-burst → s_ready follows exactly; no beat is lost or duplicated; data stays in order.
- FIFO full: ORDER_DEPTH=2 with pipeline m_ready forced on and all r_dready held low → two accepts, then no third m_valid until a last beat pops an entry.
- Reset mid-operation: assert rst_n low during beat 2 of a length-7 burst → every output takes its reset value immediately (asynchronous); after release, a new request completes normally.
- Orphan beat: drive s_valid=1 with the FIFO empty → orphan_err=1 next cycle and stays set; no r_dvalid asserted.
